// File: rtl/gencon_defs.sv
// Shared definitions for the calculator display path: converter FSM states,
// the blank display code and default result geometry.
package gencon_defs;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } bcd_state_t;

  localparam logic [3:0] BCD_BLANK     = 4'hF;
  localparam int         RESULT_WIDTH  = 16;
  localparam int         RESULT_DIGITS = 5;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: adds 3 to a BCD nibble holding 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/result_to_bcd.sv
// Iterative signed-binary to sign + packed-BCD converter, one bit per clock.
// Optional leading-zero blanking is enabled by defining RESULT_BCD_LEADING_BLANK_EN.
module result_to_bcd
  import gencon_defs::*;
#(
  parameter int WIDTH  = RESULT_WIDTH,
  parameter int DIGITS = RESULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  bcd_state_t      state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [WIDTH-1:0] mag_reg;
  logic [BW-1:0]   acc_reg;
  logic            neg_r_reg;

  logic [WIDTH-1:0] mag_in;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    acc_next;
  logic [WIDTH-1:0] mag_next;
  logic [BW-1:0]    out_digits;
  logic             unused_adj_msb;

  assign mag_in = value[WIDTH-1] ? (~value + 1'b1) : value;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .din  (acc_reg[4*gi +: 4]),
        .dout (adj[4*gi +: 4])
      );
    end
  endgenerate

  // The adjusted MSB is always shifted out; the digit-count bound keeps it 0.
  assign acc_next       = {adj[BW-2:0], mag_reg[WIDTH-1]};
  assign mag_next       = {mag_reg[WIDTH-2:0], 1'b0};
  assign unused_adj_msb = adj[BW-1];

`ifdef RESULT_BCD_LEADING_BLANK_EN
  logic leading;
  always_comb begin
    out_digits = acc_next;
    leading    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && acc_next[4*i +: 4] == 4'd0) begin
        out_digits[4*i +: 4] = BCD_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  always_comb begin
    out_digits = acc_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mag_reg   <= '0;
      acc_reg   <= '0;
      neg_r_reg <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      neg       <= 1'b0;
      bcd_out   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            neg_r_reg <= value[WIDTH-1];
            mag_reg   <= mag_in;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= CONVERT;
          end
        end
        CONVERT: begin
          acc_reg <= acc_next;
          mag_reg <= mag_next;
          cnt_reg <= cnt_reg + 1'b1;
          // Last iteration: publish the finished accumulator directly.
          if (cnt_reg == CW'(WIDTH - 1)) begin
            bcd_out   <= out_digits;
            neg       <= neg_r_reg;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_to_bcd.sv
// Self-checking bench for result_to_bcd: directed table, random values against
// a decimal-arithmetic model, back-to-back starts and mid-conversion reset.
module tb_result_to_bcd;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic        neg;
  logic [19:0] bcd_out;

  int errors = 0;
  int checks = 0;

  logic [19:0] last_bcd;
  logic        last_neg;

  always #5 clk = ~clk;

  result_to_bcd dut (
    .clk     (clk),
    .RST     (RST),
    .start   (start),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .neg     (neg),
    .bcd_out (bcd_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decimal digits from plain integer division.
  function automatic logic [19:0] model_bcd(input logic [15:0] v);
    int m;
    logic [19:0] r;
    m = int'($signed(v));
    if (m < 0) m = -m;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
`ifdef RESULT_BCD_LEADING_BLANK_EN
    for (int i = 4; i >= 1; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic run_conv(input logic [15:0] v, input logic en, input logic [19:0] eb,
                          input bit mid_start);
    int lat;
    bit busy_ok;
    bit hold_ok;
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    value = 16'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (bcd_out !== last_bcd || neg !== last_neg) hold_ok = 1'b0;
      @(negedge clk);
      value = 16'($urandom);
      start = mid_start && (lat == 5);
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'd16);
    chk("busy_during", 32'(busy_ok), 32'd1);
    chk("outputs_hold", 32'(hold_ok), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("neg", 32'(neg), 32'(en));
    chk("bcd_out", 32'(bcd_out), 32'(eb));
    $display("conv value=%h neg=%b bcd=%h lat=%0d mid_start=%0d", v, neg, bcd_out, lat, mid_start);
    last_bcd = eb;
    last_neg = en;
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [15:0] v;
    logic        n;
    logic [19:0] b;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] rv;
    int done_edge[$];
    logic [19:0] done_bcd[$];
    int guard;

`ifdef RESULT_BCD_LEADING_BLANK_EN
    vecs[0] = '{16'd12345, 1'b0, 20'h12345};
    vecs[1] = '{16'hFFFF,  1'b1, 20'hFFFF1};
    vecs[2] = '{16'h8000,  1'b1, 20'h32768};
    vecs[3] = '{16'h7FFF,  1'b0, 20'h32767};
    vecs[4] = '{16'h0000,  1'b0, 20'hFFFF0};
    vecs[5] = '{16'd1020,  1'b0, 20'hF1020};
`else
    vecs[0] = '{16'd12345, 1'b0, 20'h12345};
    vecs[1] = '{16'hFFFF,  1'b1, 20'h00001};
    vecs[2] = '{16'h8000,  1'b1, 20'h32768};
    vecs[3] = '{16'h7FFF,  1'b0, 20'h32767};
    vecs[4] = '{16'h0000,  1'b0, 20'h00000};
    vecs[5] = '{16'd1020,  1'b0, 20'h01020};
`endif

    RST = 1'b1;
    start = 1'b0;
    value = 16'd0;
    last_bcd = 20'd0;
    last_neg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_neg", 32'(neg), 32'd0);
    chk("reset_bcd", 32'(bcd_out), 32'd0);
    @(negedge clk);
    RST = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i].v, vecs[i].n, vecs[i].b, (i % 2) == 1);
    end

    for (int i = 0; i < 20; i++) begin
      rv = 16'($urandom);
      run_conv(rv, rv[15], model_bcd(rv), ($urandom % 2) == 1);
    end

    // start held high, value = 100 + edges since accept.
    @(negedge clk);
    start = 1'b1;
    value = 16'd100;
    for (int e = 0; e < 36; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_edge.push_back(e);
        done_bcd.push_back(bcd_out);
      end
      @(negedge clk);
      value = 16'(100 + e + 1);
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(done_edge.size()), 32'd2);
    if (done_edge.size() >= 2) begin
      chk("b2b_first_edge", 32'(done_edge[0]), 32'd16);
      chk("b2b_first_bcd", 32'(done_bcd[0]), 32'(model_bcd(16'd100)));
      chk("b2b_second_edge", 32'(done_edge[1]), 32'd33);
      chk("b2b_second_bcd", 32'(done_bcd[1]), 32'(model_bcd(16'd117)));
      $display("b2b done_edges=%0d,%0d bcd=%h,%h", done_edge[0], done_edge[1], done_bcd[0], done_bcd[1]);
    end
    guard = 0;
    while (busy && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("b2b_drain", 32'(busy), 32'd0);
    last_bcd = model_bcd(16'd134);
    last_neg = 1'b0;
    chk("b2b_third_bcd", 32'(bcd_out), 32'(last_bcd));

    // Reset at N+8 while converting 999: nothing published, no done.
    @(negedge clk);
    start = 1'b1;
    value = 16'd999;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_neg", 32'(neg), 32'd0);
    chk("midrst_bcd", 32'(bcd_out), 32'd0);
    $display("midrst busy=%b done=%b neg=%b bcd=%h", busy, done, neg, bcd_out);
    @(negedge clk);
    RST = 1'b0;
    last_bcd = 20'd0;
    last_neg = 1'b0;
    guard = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) guard++;
    end
    chk("midrst_no_done", 32'(guard), 32'd0);
    run_conv(16'd999, 1'b0, model_bcd(16'd999), 1'b0);

    // Reset and start together: request dropped.
    @(negedge clk);
    RST = 1'b1;
    start = 1'b1;
    value = 16'd42;
    @(posedge clk);
    #1;
    chk("rst_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    RST = 1'b0;
    start = 1'b0;
    last_bcd = 20'd0;
    last_neg = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_start_idle", 32'(busy), 32'd0);
    run_conv(16'hFFD6, 1'b1, model_bcd(16'hFFD6), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_to_bcd.md
# result_to_bcd

Sequential signed-binary-to-decimal converter for the calculator's display path. It takes the 16-bit two's-complement result the controller produces and turns it into a sign flag plus packed BCD digits. It is the inverse of the controller's digit-accumulation path, which builds operands as `op*10 + digit`. Conversion is iterative double-dabble, one bit per clock, with a start/done handshake toward the controller.

## Interface
- `WIDTH`, default 16: input result width, two's complement.
- `DIGITS`, default 5: BCD digits produced. Must satisfy 10^DIGITS > 2^(WIDTH-1).
- `clk` input 1: single clock; all state updates on the rising edge.
- `RST` input 1: synchronous reset, active-high.
- `start` input 1: request conversion of `value`. Sampled only while idle.
- `value` input WIDTH: signed result to convert. Captured on the accepting edge.
- `busy` output 1: conversion in progress. Reset 0.
- `done` output 1: one-cycle pulse when `bcd_out`/`neg` update. Reset 0.
- `neg` output 1: sign of the last converted value. Reset 0.
- `bcd_out` output 4*DIGITS: packed digits, most significant nibble = most significant digit. Reset all 0.

## Operation
- States: IDLE, CONVERT.
- IDLE, `start`=1 at edge N:
  - capture `neg_r = value[WIDTH-1]`;
  - magnitude = `neg_r ? (~value + 1) : value`, held as WIDTH-bit unsigned (−32768 → 16'h8000 = 32768);
  - load the magnitude into the shift register, clear the BCD accumulator, clear the counter, set `busy`, go to CONVERT.
- CONVERT, one iteration per edge:
  - every BCD nibble ≥ 5 gets +3;
  - then shift {BCD accumulator, magnitude} left by 1;
  - counter increments.
- After the WIDTH-th iteration:
  - register the accumulator into `bcd_out` and `neg_r` into `neg`;
  - pulse `done`, clear `busy`, return to IDLE.
- `start` in CONVERT is ignored; it is neither queued nor restarting. `value` changes after the accepting edge have no effect.
- `bcd_out`/`neg` hold their last result until the next completed conversion. Intermediate accumulator values are never visible on the outputs.
- `RST` in any state: return to IDLE and clear every output and internal register on that edge. A conversion interrupted by reset never pulses `done`.
- Arithmetic: the add-3 is per nibble on 4 bits, with no carry between nibbles. The counter is `$clog2(WIDTH+1)` bits.

## Timing
- Accepting edge N: `busy`=1 visible after N.
- Iterations on edges N+1 … N+WIDTH (16). On edge N+16: `bcd_out`, `neg` update, `done`=1, `busy`=0.
- Edge N+17: `done`=0. Earliest next accept is edge N+17 if `start` is high.
- Latency start-to-done: WIDTH cycles. Throughput: one conversion per WIDTH+1 cycles.
- `start` held continuously high gives back-to-back conversions at that rate.
- Simultaneous `RST` and `start`: reset wins, the request is dropped.

## Configuration
- `RESULT_BCD_LEADING_BLANK_EN` defined: at the register stage on the done edge, leading zero nibbles are replaced by the blank code 4'hF. The least significant digit is never blanked, so 0 displays as FFFF0.
- Undefined: `bcd_out` carries plain BCD with leading zeros.
- Conversion latency is identical in both builds.

## Structure
- Shared package `gencon_defs.sv` holds:
  - `bcd_state_t` enum (IDLE, CONVERT);
  - `BCD_BLANK` = 4'hF;
  - default `RESULT_WIDTH` = 16 and `RESULT_DIGITS` = 5 constants.
- Sub-module `bcd_digit_adjust`: a combinational 4-bit add-3-if-≥5 cell, instantiated DIGITS times via generate.
- The top module owns the FSM, counter, shift register and output registers.

## Test plan
- `value`=16'd12345, `start` pulsed at edge N → `done` at N+16, `neg`=0, `bcd_out`=20'h12345; `busy` high N..N+15.
- `value`=16'hFFFF (−1) → `neg`=1, `bcd_out`=20'h00001. With `RESULT_BCD_LEADING_BLANK_EN`: 20'hFFFF1.
- `value`=16'h8000 (−32768) → `neg`=1, `bcd_out`=20'h32768. `value`=16'h7FFF → `neg`=0, 20'h32767.
- `value`=0 → `bcd_out`=20'h00000, or 20'hFFFF0 with blanking; `neg`=0.
- `start` held high with `value` changing every cycle from 100 → only the value at the accepting edge is converted. The next accept is at N+17 and the next `done` at N+33.
- `RST` asserted at edge N+8 mid-conversion of 999 → all outputs 0 and `busy`=0 after that edge, no `done` pulse. A new `start` the following cycle converts correctly.
